sb_rdi_cfg_rx_buffer: RTL and testbench
=======================================

# sb_rdi_cfg_rx_buffer

PHY-side receiver for RDI sideband configuration messages sent by the adapter on lp_cfg/lp_cfg_vld. It frames each message (one contiguous run of lp_cfg_vld-high beats), stores complete messages in a store-and-forward word FIFO, and presents them to the sideband packetizer. It returns one pl_cfg_crd pulse per drained message, which is the credit the adapter's own credit counter consumes on each message it sends. After reset the adapter owns DEPTH credits.

## Interface
- NC, 32, lp_cfg word width in bits
- DEPTH, 32, message slots; equals the adapter's initial credit count
- MAX_BEATS, 4, maximum beats per message; word FIFO depth = DEPTH*MAX_BEATS
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_lp_cfg  in  NC  config message word from adapter
- i_lp_cfg_vld  in  1  word valid; a message is a maximal run of consecutive high cycles
- o_pl_cfg_crd  out  1  one-cycle credit-return pulse to adapter, one per message drained
- o_msg_data  out  NC  head-of-FIFO word
- o_msg_vld  out  1  head word valid; high only while ≥1 complete message is stored
- o_msg_last  out  1  head word is the final beat of its message
- i_msg_rdy  in  1  consumer accepts head word when o_msg_vld && i_msg_rdy
- o_msg_count  out  $clog2(DEPTH+1)  complete messages stored
- o_err_overflow  out  1  sticky: message arrived with no slot free
- o_err_too_long  out  1  sticky: message exceeded MAX_BEATS

## Operation
- Staging register holds each accepted beat for one cycle. Next cycle: vld high and beat_cnt<MAX_BEATS → push held word with last=0; vld low or beat_cnt==MAX_BEATS → push held word with last=1 and close the message.
- beat_cnt counts beats of the current message and clears at message close; beats after MAX_BEATS are discarded and set o_err_too_long (CFG_RX_ERR_CHECK_EN).
- occupied counter (0..DEPTH): +1 on message start (vld rising edge, accepted), −1 on each credit pulse. At vld rising edge with occupied==DEPTH the whole message is dropped (no push, no staging, no credit) and o_err_overflow is set.
- o_msg_count: +1 when a last=1 word is pushed, −1 when a last=1 word is popped; both in the same cycle → unchanged.
- Pop with o_msg_last=1 → o_pl_cfg_crd high the next cycle, for exactly one cycle. Simultaneous message start and credit return: occupied is unchanged.
- Push and pop in the same cycle are both allowed. FIFO pointers wrap modulo DEPTH*MAX_BEATS.
- Store-and-forward: a message is never exposed to the consumer until its last beat is pushed.

## Timing
- Reset values: o_pl_cfg_crd=0, o_msg_vld=0, o_msg_last=0, o_msg_data=0, o_msg_count=0, both error flags 0; all counters, pointers and staging cleared.
- Input beat to FIFO push: 1 cycle. Final beat to o_msg_vld high: 2 cycles after that beat (1 cycle to detect vld low, 1 to push).
- Last-word pop to o_pl_cfg_crd: 1 cycle. Reset asserted mid-message or mid-drain: partial data is discarded and no credit pulse is issued; the adapter resets its credits to DEPTH in parallel.
- Message back-to-back separation: vld must be low for ≥1 cycle between messages (protocol requirement, not checked).

## Configuration
- CFG_RX_ERR_CHECK_EN defined: o_err_overflow and o_err_too_long are implemented as sticky flags, cleared only by reset.
- Not defined: both error outputs are tied 0. Drop and truncate behaviour is unchanged.

## Test plan
- 1 message of 3 beats (0xA1,0xA2,0xA3), i_msg_rdy=1 → o_msg_vld two cycles after 0xA3, data A1/A2/A3 with last on A3, o_pl_cfg_crd one pulse one cycle after A3 pops, o_msg_count 0→1→0.
- 32 one-beat messages with i_msg_rdy=0, then a 33rd → o_msg_count=32, 33rd dropped, o_err_overflow=1, no credit; raise rdy → exactly 32 credit pulses.
- 6-beat message with MAX_BEATS=4 → 4 words stored, last on beat 4, o_err_too_long=1, one credit returned.
- Continuous drain while a new message arrives, with the credit pulse in the same cycle as the new rising edge → occupied unchanged, no lost or duplicated credit.
- Reset asserted mid-message with 2 messages buffered → all outputs at reset values next edge; no credit pulses; a fresh 1-beat message then works normally.
- Build without CFG_RX_ERR_CHECK_EN and repeat the overflow scenario → message dropped, o_err_overflow stays 0.

Source files
------------

// File: rtl/sb_rdi_cfg_rx_buffer.sv
// RDI sideband config receiver: frames lp_cfg messages, store-and-forward FIFO, credit return.
// Optional sticky error flags are built when CFG_RX_ERR_CHECK_EN is defined.
module sb_rdi_cfg_rx_buffer #(
  parameter int unsigned NC        = 32,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned MAX_BEATS = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NC-1:0]              i_lp_cfg,
  input  logic                       i_lp_cfg_vld,
  output logic                       o_pl_cfg_crd,
  output logic [NC-1:0]              o_msg_data,
  output logic                       o_msg_vld,
  output logic                       o_msg_last,
  input  logic                       i_msg_rdy,
  output logic [$clog2(DEPTH+1)-1:0] o_msg_count,
  output logic                       o_err_overflow,
  output logic                       o_err_too_long
);

  localparam int unsigned FD = DEPTH * MAX_BEATS;
  localparam int unsigned PW = (FD > 1) ? $clog2(FD) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned BW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DISCARD
  } state_t;

  state_t          state_q, state_d;
  logic [NC-1:0]   stg_q, stg_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [CW-1:0]   occ_q, msg_cnt_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic            crd_q;
  logic            start, push, push_last, set_ovf, set_long;
  logic            pop, pop_last;
  logic [NC:0]     mem [FD];
  logic [NC:0]     head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
  endfunction

  // S_RECV means the staging register holds a beat awaiting push; its
  // last flag is only known once the following cycle's vld is seen.
  always_comb begin
    state_d   = state_q;
    stg_d     = stg_q;
    beat_d    = beat_q;
    start     = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    set_ovf   = 1'b0;
    set_long  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_lp_cfg_vld) begin
          if (occ_q == CW'(DEPTH)) begin
            set_ovf = 1'b1;
            state_d = S_DISCARD;
          end else begin
            start   = 1'b1;
            stg_d   = i_lp_cfg;
            beat_d  = BW'(1);
            state_d = S_RECV;
          end
        end
      end
      S_RECV: begin
        push = 1'b1;
        if (!i_lp_cfg_vld) begin
          push_last = 1'b1;
          beat_d    = '0;
          state_d   = S_IDLE;
        end else if (beat_q == BW'(MAX_BEATS)) begin
          push_last = 1'b1;
          set_long  = 1'b1;
          beat_d    = '0;
          state_d   = S_DISCARD;
        end else begin
          stg_d  = i_lp_cfg;
          beat_d = beat_q + 1'b1;
        end
      end
      S_DISCARD: begin
        if (!i_lp_cfg_vld) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign head       = mem[rd_ptr_q];
  assign o_msg_vld  = (msg_cnt_q != '0);
  assign o_msg_data = o_msg_vld ? head[NC-1:0] : '0;
  assign o_msg_last = o_msg_vld & head[NC];
  assign pop        = o_msg_vld & i_msg_rdy;
  assign pop_last   = pop & head[NC];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      stg_q     <= '0;
      beat_q    <= '0;
      occ_q     <= '0;
      msg_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      crd_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      stg_q   <= stg_d;
      beat_q  <= beat_d;
      crd_q   <= pop_last;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (start && !crd_q)      occ_q <= occ_q + 1'b1;
      else if (!start && crd_q) occ_q <= occ_q - 1'b1;
      if (push_last && !pop_last)      msg_cnt_q <= msg_cnt_q + 1'b1;
      else if (!push_last && pop_last) msg_cnt_q <= msg_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= {push_last, stg_q};
  end

  assign o_pl_cfg_crd = crd_q;
  assign o_msg_count  = msg_cnt_q;

`ifdef CFG_RX_ERR_CHECK_EN
  logic err_ovf_q, err_long_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_ovf_q  <= 1'b0;
      err_long_q <= 1'b0;
    end else begin
      if (set_ovf)  err_ovf_q  <= 1'b1;
      if (set_long) err_long_q <= 1'b1;
    end
  end

  assign o_err_overflow = err_ovf_q;
  assign o_err_too_long = err_long_q;
`else
  logic err_set_unused;
  assign err_set_unused = set_ovf | set_long;
  assign o_err_overflow = 1'b0;
  assign o_err_too_long = 1'b0;
`endif

endmodule

// File: tb/tb_sb_rdi_cfg_rx_buffer.sv
// Self-checking bench for sb_rdi_cfg_rx_buffer: directed scenarios plus a randomized run
// against a message-level event-calendar model.
module tb_sb_rdi_cfg_rx_buffer;

  localparam int NC        = 32;
  localparam int DEPTH     = 32;
  localparam int MAX_BEATS = 4;
  localparam int CW        = $clog2(DEPTH + 1);
  localparam int NCYC      = 1600;
`ifdef CFG_RX_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [NC-1:0] i_lp_cfg;
  logic          i_lp_cfg_vld;
  logic          o_pl_cfg_crd;
  logic [NC-1:0] o_msg_data;
  logic          o_msg_vld;
  logic          o_msg_last;
  logic          i_msg_rdy;
  logic [CW-1:0] o_msg_count;
  logic          o_err_overflow;
  logic          o_err_too_long;

  int checks = 0;
  int errors = 0;
  int crd_total = 0;

  logic          sv [NCYC];
  logic [NC-1:0] sd [NCYC];
  int            slen [NCYC];

  sb_rdi_cfg_rx_buffer #(.NC(NC), .DEPTH(DEPTH), .MAX_BEATS(MAX_BEATS)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_lp_cfg      (i_lp_cfg),
    .i_lp_cfg_vld  (i_lp_cfg_vld),
    .o_pl_cfg_crd  (o_pl_cfg_crd),
    .o_msg_data    (o_msg_data),
    .o_msg_vld     (o_msg_vld),
    .o_msg_last    (o_msg_last),
    .i_msg_rdy     (i_msg_rdy),
    .o_msg_count   (o_msg_count),
    .o_err_overflow(o_err_overflow),
    .o_err_too_long(o_err_too_long)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_pl_cfg_crd === 1'b1) crd_total++;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    i_rst_n = 1'b0; i_lp_cfg_vld = 1'b0; i_lp_cfg = '0; i_msg_rdy = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic send_one(input logic [NC-1:0] d);
    @(negedge i_clk); i_lp_cfg_vld = 1'b1; i_lp_cfg = d;
    @(negedge i_clk); i_lp_cfg_vld = 1'b0; i_lp_cfg = '0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_lp_cfg_vld = 1'b0; i_lp_cfg = '0; i_msg_rdy = 1'b0;
    @(negedge i_clk);
    checks++; if (o_msg_vld !== 1'b0) begin errors++; $display("FAIL rst_vld got=%0b exp=0", o_msg_vld); end
    checks++; if (o_msg_last !== 1'b0) begin errors++; $display("FAIL rst_last got=%0b exp=0", o_msg_last); end
    checks++; if (o_msg_data !== '0) begin errors++; $display("FAIL rst_data got=%h exp=0", o_msg_data); end
    checks++; if (o_msg_count !== '0) begin errors++; $display("FAIL rst_count got=%0d exp=0", o_msg_count); end
    checks++; if (o_pl_cfg_crd !== 1'b0) begin errors++; $display("FAIL rst_crd got=%0b exp=0", o_pl_cfg_crd); end
    checks++; if (o_err_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%0b exp=0", o_err_overflow); end
    checks++; if (o_err_too_long !== 1'b0) begin errors++; $display("FAIL rst_long got=%0b exp=0", o_err_too_long); end
  endtask

  task automatic test_single();
    int base;
    apply_reset(); base = crd_total; i_msg_rdy = 1'b1;
    @(negedge i_clk); i_lp_cfg_vld = 1'b1; i_lp_cfg = 32'hA1;
    @(negedge i_clk); i_lp_cfg = 32'hA2;
    @(negedge i_clk); i_lp_cfg = 32'hA3;
    @(negedge i_clk); i_lp_cfg_vld = 1'b0; i_lp_cfg = '0;
    checks++; if (o_msg_vld !== 1'b0) begin errors++; $display("FAIL single_early_vld got=%0b exp=0", o_msg_vld); end
    @(negedge i_clk);
    checks++; if (o_msg_vld !== 1'b1 || o_msg_data !== 32'hA1 || o_msg_last !== 1'b0)
      begin errors++; $display("FAIL single_w0 got=%0b/%h/%0b exp=1/a1/0", o_msg_vld, o_msg_data, o_msg_last); end
    checks++; if (o_msg_count !== CW'(1)) begin errors++; $display("FAIL single_cnt1 got=%0d exp=1", o_msg_count); end
    @(negedge i_clk);
    checks++; if (o_msg_data !== 32'hA2 || o_msg_last !== 1'b0)
      begin errors++; $display("FAIL single_w1 got=%h/%0b exp=a2/0", o_msg_data, o_msg_last); end
    @(negedge i_clk);
    checks++; if (o_msg_data !== 32'hA3 || o_msg_last !== 1'b1 || o_pl_cfg_crd !== 1'b0)
      begin errors++; $display("FAIL single_w2 got=%h/%0b crd=%0b exp=a3/1 crd=0", o_msg_data, o_msg_last, o_pl_cfg_crd); end
    @(negedge i_clk);
    checks++; if (o_pl_cfg_crd !== 1'b1) begin errors++; $display("FAIL single_crd got=%0b exp=1", o_pl_cfg_crd); end
    checks++; if (o_msg_count !== '0 || o_msg_vld !== 1'b0)
      begin errors++; $display("FAIL single_cnt0 got=%0d/%0b exp=0/0", o_msg_count, o_msg_vld); end
    @(negedge i_clk);
    checks++; if (o_pl_cfg_crd !== 1'b0) begin errors++; $display("FAIL single_crd_width got=%0b exp=0", o_pl_cfg_crd); end
    checks++; if (crd_total - base !== 1) begin errors++; $display("FAIL single_crd_total got=%0d exp=1", crd_total - base); end
  endtask

  task automatic test_overflow();
    int base;
    apply_reset(); base = crd_total;
    for (int i = 0; i < DEPTH; i++) send_one(32'hC000_0000 | i);
    send_one(32'hDEAD_BEEF);
    repeat (3) @(negedge i_clk);
    checks++; if (o_msg_count !== CW'(DEPTH)) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", o_msg_count, DEPTH); end
    checks++; if (o_err_overflow !== ERR_EN) begin errors++; $display("FAIL ovf_flag got=%0b exp=%0b", o_err_overflow, ERR_EN); end
    checks++; if (crd_total - base !== 0) begin errors++; $display("FAIL ovf_no_crd got=%0d exp=0", crd_total - base); end
    i_msg_rdy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (o_msg_vld !== 1'b1 || o_msg_data !== (32'hC000_0000 | i) || o_msg_last !== 1'b1) begin
        errors++; $display("FAIL ovf_drain%0d got=%0b/%h/%0b exp=1/%h/1", i, o_msg_vld, o_msg_data, o_msg_last, 32'hC000_0000 | i);
      end
      @(negedge i_clk);
    end
    repeat (2) @(negedge i_clk);
    checks++; if (o_msg_vld !== 1'b0 || o_msg_count !== '0)
      begin errors++; $display("FAIL ovf_empty got=%0b/%0d exp=0/0", o_msg_vld, o_msg_count); end
    checks++; if (crd_total - base !== DEPTH) begin errors++; $display("FAIL ovf_crd_total got=%0d exp=%0d", crd_total - base, DEPTH); end
    checks++; if (o_err_overflow !== ERR_EN) begin errors++; $display("FAIL ovf_sticky got=%0b exp=%0b", o_err_overflow, ERR_EN); end
  endtask

  task automatic test_too_long();
    int base;
    apply_reset(); base = crd_total;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk); i_lp_cfg_vld = 1'b1; i_lp_cfg = 32'hD0 + i;
    end
    @(negedge i_clk); i_lp_cfg_vld = 1'b0; i_lp_cfg = '0;
    repeat (3) @(negedge i_clk);
    checks++; if (o_msg_count !== CW'(1)) begin errors++; $display("FAIL long_count got=%0d exp=1", o_msg_count); end
    checks++; if (o_err_too_long !== ERR_EN) begin errors++; $display("FAIL long_flag got=%0b exp=%0b", o_err_too_long, ERR_EN); end
    checks++; if (o_err_overflow !== 1'b0) begin errors++; $display("FAIL long_ovf got=%0b exp=0", o_err_overflow); end
    i_msg_rdy = 1'b1;
    for (int i = 0; i < MAX_BEATS; i++) begin
      checks++;
      if (o_msg_vld !== 1'b1 || o_msg_data !== 32'hD0 + i || o_msg_last !== (i == MAX_BEATS - 1)) begin
        errors++; $display("FAIL long_w%0d got=%0b/%h/%0b exp=1/%h/%0b", i, o_msg_vld, o_msg_data, o_msg_last, 32'hD0 + i, i == MAX_BEATS - 1);
      end
      @(negedge i_clk);
    end
    checks++; if (o_msg_vld !== 1'b0) begin errors++; $display("FAIL long_extra got=%0b exp=0", o_msg_vld); end
    repeat (2) @(negedge i_clk);
    checks++; if (crd_total - base !== 1) begin errors++; $display("FAIL long_crd got=%0d exp=1", crd_total - base); end
  endtask

  task automatic test_back_to_back();
    int base;
    apply_reset(); base = crd_total; i_msg_rdy = 1'b1;
    @(negedge i_clk); i_lp_cfg_vld = 1'b1; i_lp_cfg = 32'hB0;
    @(negedge i_clk); i_lp_cfg_vld = 1'b0; i_lp_cfg = '0;
    @(negedge i_clk);
    checks++; if (o_msg_vld !== 1'b1 || o_msg_data !== 32'hB0)
      begin errors++; $display("FAIL b2b_head got=%0b/%h exp=1/b0", o_msg_vld, o_msg_data); end
    @(negedge i_clk);
    checks++; if (o_pl_cfg_crd !== 1'b1) begin errors++; $display("FAIL b2b_crd got=%0b exp=1", o_pl_cfg_crd); end
    i_lp_cfg_vld = 1'b1; i_lp_cfg = 32'hB1; i_msg_rdy = 1'b0;
    @(negedge i_clk); i_lp_cfg_vld = 1'b0; i_lp_cfg = '0;
    for (int i = 0; i < DEPTH - 1; i++) send_one(32'hC100_0000 | i);
    send_one(32'hDEAD_0001);
    repeat (3) @(negedge i_clk);
    checks++; if (o_msg_count !== CW'(DEPTH)) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", o_msg_count, DEPTH); end
    checks++; if (o_err_overflow !== ERR_EN) begin errors++; $display("FAIL b2b_ovf got=%0b exp=%0b", o_err_overflow, ERR_EN); end
    checks++; if (o_msg_data !== 32'hB1) begin errors++; $display("FAIL b2b_first got=%h exp=b1", o_msg_data); end
    i_msg_rdy = 1'b1;
    repeat (DEPTH + 3) @(negedge i_clk);
    checks++; if (o_msg_vld !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%0b exp=0", o_msg_vld); end
    checks++; if (crd_total - base !== DEPTH + 1) begin errors++; $display("FAIL b2b_crd_total got=%0d exp=%0d", crd_total - base, DEPTH + 1); end
  endtask

  task automatic test_reset_mid();
    int base;
    apply_reset(); base = crd_total;
    send_one(32'hE1); send_one(32'hE2);
    @(negedge i_clk); i_lp_cfg_vld = 1'b1; i_lp_cfg = 32'hE3;
    checks++; if (o_msg_count !== CW'(2)) begin errors++; $display("FAIL rmid_pre_count got=%0d exp=2", o_msg_count); end
    @(negedge i_clk); i_lp_cfg = 32'hE4;
    @(negedge i_clk); i_msg_rdy = 1'b1;
    #2 i_rst_n = 1'b0; i_lp_cfg_vld = 1'b0; i_lp_cfg = '0;
    #1;
    checks++; if (o_msg_vld !== 1'b0 || o_msg_data !== '0 || o_msg_last !== 1'b0 || o_msg_count !== '0)
      begin errors++; $display("FAIL rmid_outs got=%0b/%h/%0b/%0d exp=0/0/0/0", o_msg_vld, o_msg_data, o_msg_last, o_msg_count); end
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    checks++; if (crd_total - base !== 0) begin errors++; $display("FAIL rmid_no_crd got=%0d exp=0", crd_total - base); end
    checks++; if (o_msg_vld !== 1'b0) begin errors++; $display("FAIL rmid_idle got=%0b exp=0", o_msg_vld); end
    send_one(32'hF1);
    @(negedge i_clk);
    checks++; if (o_msg_vld !== 1'b1 || o_msg_data !== 32'hF1 || o_msg_last !== 1'b1)
      begin errors++; $display("FAIL rmid_fresh got=%0b/%h/%0b exp=1/f1/1", o_msg_vld, o_msg_data, o_msg_last); end
    repeat (2) @(negedge i_clk);
    checks++; if (crd_total - base !== 1) begin errors++; $display("FAIL rmid_crd got=%0d exp=1", crd_total - base); end
  endtask

  // Model: an accepted message keeping K beats pushes word j after edge start+j+1.
  task automatic test_random();
    int          pe [$];
    logic [NC:0] pw [$];
    logic [NC:0] m_words [$];
    logic [NC:0] w;
    int          m_occ, m_complete, c, gap, len, k, phase;
    bit          m_crd, crd_next, m_ovf, m_long;
    int          pct [7];
    logic          exp_vld, exp_last;
    logic [NC-1:0] exp_data;
    pct = '{70, 5, 50, 0, 30, 100, 100};
    for (int i = 0; i < NCYC; i++) begin sv[i] = 1'b0; sd[i] = $urandom; slen[i] = 0; end
    c = 0;
    while (1) begin
      gap = $urandom_range(1, 3); len = $urandom_range(1, 6);
      c += gap;
      if (c + len >= NCYC - 200) break;
      slen[c] = len;
      for (int j = 0; j < len; j++) sv[c + j] = 1'b1;
      c += len;
    end
    apply_reset();
    m_occ = 0; m_complete = 0; m_crd = 0; m_ovf = 0; m_long = 0;
    for (int cy = 0; cy < NCYC; cy++) begin
      @(negedge i_clk);
      exp_vld  = (m_complete > 0);
      exp_data = exp_vld ? m_words[0][NC-1:0] : '0;
      exp_last = exp_vld ? m_words[0][NC] : 1'b0;
      checks++; if (o_msg_vld !== exp_vld || o_msg_data !== exp_data || o_msg_last !== exp_last)
        begin errors++; $display("FAIL rnd_head c%0d got=%0b/%h/%0b exp=%0b/%h/%0b", cy, o_msg_vld, o_msg_data, o_msg_last, exp_vld, exp_data, exp_last); end
      checks++; if (o_msg_count !== CW'(m_complete))
        begin errors++; $display("FAIL rnd_count c%0d got=%0d exp=%0d", cy, o_msg_count, m_complete); end
      checks++; if (o_pl_cfg_crd !== m_crd)
        begin errors++; $display("FAIL rnd_crd c%0d got=%0b exp=%0b", cy, o_pl_cfg_crd, m_crd); end
      checks++; if (o_err_overflow !== (ERR_EN & m_ovf) || o_err_too_long !== (ERR_EN & m_long))
        begin errors++; $display("FAIL rnd_err c%0d got=%0b/%0b exp=%0b/%0b", cy, o_err_overflow, o_err_too_long, ERR_EN & m_ovf, ERR_EN & m_long); end
      phase = cy / 250;
      i_lp_cfg_vld = sv[cy]; i_lp_cfg = sd[cy];
      i_msg_rdy = ($urandom_range(0, 99) < pct[phase]);
      crd_next = 1'b0;
      if (m_complete > 0 && i_msg_rdy) begin
        w = m_words.pop_front();
        if (w[NC]) begin m_complete--; crd_next = 1'b1; end
      end
      if (pe.size() > 0 && pe[0] == cy) begin
        void'(pe.pop_front()); w = pw.pop_front();
        m_words.push_back(w);
        if (w[NC]) m_complete++;
      end
      if (slen[cy] != 0) begin
        if (m_occ == DEPTH) m_ovf = 1'b1;
        else begin
          m_occ++;
          k = (slen[cy] > MAX_BEATS) ? MAX_BEATS : slen[cy];
          if (slen[cy] > MAX_BEATS) m_long = 1'b1;
          for (int j = 0; j < k; j++) begin
            pe.push_back(cy + 1 + j);
            pw.push_back({j == k - 1, sd[cy + j]});
          end
        end
      end
      if (m_crd) m_occ--;
      m_crd = crd_next;
    end
    i_lp_cfg_vld = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_too_long();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
